// File: rtl/fpga_config_writer_pkg.sv
// rtl/fpga_config_writer_pkg.sv - shared image layout, state encoding and record types
// Used by both the configuration writer and the image reader.
package fpga_config_writer_pkg;

  localparam logic [31:0] CFG_MAGIC = 32'h41544746;

  localparam int HDR_SIZE  = 16;
  localparam int HDR_WORDS = 4;
  localparam int REC_SIZE  = 44;
  localparam int REC_WORDS = 11;

  // Header byte offsets
  localparam int HDR_MAGIC_OFF   = 0;
  localparam int HDR_VERSION_OFF = 4;
  localparam int HDR_COUNT_OFF   = 8;
  localparam int HDR_TS_OFF      = 12;

  // Record byte offsets, relative to the record base
  localparam int REC_SWITCH_OFF = 0;
  localparam int REC_HOST_OFF   = 4;
  localparam int REC_LIP_OFF    = 8;
  localparam int REC_PIP_OFF    = 12;
  localparam int REC_PORT_OFF   = 16;
  localparam int REC_QP_OFF     = 20;
  localparam int REC_MAC0_OFF   = 24;
  localparam int REC_MAC1_OFF   = 28;
  localparam int REC_MAC2_OFF   = 32;
  localparam int REC_UP_OFF     = 36;
  localparam int REC_RSVD_OFF   = 40;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INVALIDATE,
    ST_ACCEPT,
    ST_WRITE_CONN,
    ST_WRITE_HDR,
    ST_DONE
  } cfg_state_t;

  typedef struct packed {
    logic [31:0] switch_id;
    logic [31:0] host_id;
    logic [31:0] local_ip;
    logic [31:0] peer_ip;
    logic [15:0] local_port;
    logic [15:0] peer_port;
    logic [15:0] local_qp;
    logic [15:0] peer_qp;
    logic [47:0] local_mac;
    logic [47:0] peer_mac;
    logic        up;
  } conn_rec_t;

  typedef logic [REC_WORDS-1:0][31:0] rec_words_t;

endpackage

// File: rtl/fpga_config_record_pack.sv
// rtl/fpga_config_record_pack.sv - combinational connection record to 11-word packing
// MAC addresses are laid out byte-serially (first octet at the lowest byte address).
module fpga_config_record_pack
  import fpga_config_writer_pkg::*;
(
  input  conn_rec_t  rec,
  output rec_words_t words
);

  always_comb begin
    words = '0;
    words[REC_SWITCH_OFF/4] = rec.switch_id;
    words[REC_HOST_OFF/4]   = rec.host_id;
    words[REC_LIP_OFF/4]    = rec.local_ip;
    words[REC_PIP_OFF/4]    = rec.peer_ip;
    words[REC_PORT_OFF/4]   = {rec.peer_port, rec.local_port};
    words[REC_QP_OFF/4]     = {rec.peer_qp, rec.local_qp};
    words[REC_MAC0_OFF/4]   = {rec.local_mac[23:16], rec.local_mac[31:24],
                               rec.local_mac[39:32], rec.local_mac[47:40]};
    words[REC_MAC1_OFF/4]   = {rec.peer_mac[39:32], rec.peer_mac[47:40],
                               rec.local_mac[7:0], rec.local_mac[15:8]};
    words[REC_MAC2_OFF/4]   = {rec.peer_mac[7:0], rec.peer_mac[15:8],
                               rec.peer_mac[23:16], rec.peer_mac[31:24]};
    words[REC_UP_OFF/4]     = {24'h0, 7'h0, rec.up};
    words[REC_RSVD_OFF/4]   = 32'h0;
  end

endmodule

// File: rtl/fpga_config_writer.sv
// rtl/fpga_config_writer.sv - writes a configuration image (header + connection records) to memory
// The magic word is invalidated first and written last so a partial image is never trusted.
module fpga_config_writer
  import fpga_config_writer_pkg::*;
#(
  parameter int          MAX_CONNECTIONS = 64,
  parameter int          ADDR_WIDTH      = 32,
  parameter int          DATA_WIDTH      = 32,
  parameter logic [31:0] CFG_VERSION     = 32'h1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  commit,
  input  logic [31:0]           timestamp_in,
  input  logic                  conn_wr_valid,
  output logic                  conn_wr_ready,
  input  logic [31:0]           conn_switch_id,
  input  logic [31:0]           conn_host_id,
  input  logic [31:0]           conn_local_ip,
  input  logic [31:0]           conn_peer_ip,
  input  logic [15:0]           conn_local_port,
  input  logic [15:0]           conn_peer_port,
  input  logic [15:0]           conn_local_qp,
  input  logic [15:0]           conn_peer_qp,
  input  logic [47:0]           conn_local_mac,
  input  logic [47:0]           conn_peer_mac,
  input  logic                  conn_up,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  mem_we,
  output logic                  busy,
  output logic                  done,
  output logic                  overflow_error,
  output logic [6:0]            conn_count
);

  localparam logic [6:0] MAX_CNT = 7'(MAX_CONNECTIONS);

  cfg_state_t state, next_state;
  conn_rec_t  in_rec, rec;
  rec_words_t rec_words;

  logic [3:0]  word_idx;
  logic [1:0]  hdr_idx;
  logic        pend_commit;
  logic [31:0] ts_reg;
  logic [6:0]  count;
  logic        ovf;

  logic                  transfer, start_ok, last_word, last_hdr;
  logic [ADDR_WIDTH-1:0] rec_addr, hdr_addr;
  logic [31:0]           hdr_data;

  assign in_rec = '{switch_id:  conn_switch_id,  host_id:   conn_host_id,
                    local_ip:   conn_local_ip,   peer_ip:   conn_peer_ip,
                    local_port: conn_local_port, peer_port: conn_peer_port,
                    local_qp:   conn_local_qp,   peer_qp:   conn_peer_qp,
                    local_mac:  conn_local_mac,  peer_mac:  conn_peer_mac,
                    up:         conn_up};

  fpga_config_record_pack u_pack (
    .rec   (rec),
    .words (rec_words)
  );

  assign conn_wr_ready  = (state == ST_ACCEPT) && (count < MAX_CNT);
  assign transfer       = conn_wr_valid && conn_wr_ready;
  assign start_ok       = start && ((state == ST_IDLE) || (state == ST_DONE));
  assign last_word      = (word_idx == 4'(REC_WORDS - 1));
  assign last_hdr       = (hdr_idx == 2'(HDR_WORDS - 1));
  assign done           = (state == ST_DONE);
  assign overflow_error = ovf;
  assign conn_count     = count;

  assign rec_addr = ADDR_WIDTH'(HDR_SIZE)
                  + ADDR_WIDTH'(count) * ADDR_WIDTH'(REC_SIZE)
                  + ADDR_WIDTH'({word_idx, 2'b00});

  // Magic goes out last so a reader never sees a header before its fields are valid
  always_comb begin
    hdr_addr = ADDR_WIDTH'(HDR_MAGIC_OFF);
    hdr_data = CFG_MAGIC;
    case (hdr_idx)
      2'd0: begin hdr_addr = ADDR_WIDTH'(HDR_VERSION_OFF); hdr_data = CFG_VERSION;     end
      2'd1: begin hdr_addr = ADDR_WIDTH'(HDR_COUNT_OFF);   hdr_data = {25'h0, count}; end
      2'd2: begin hdr_addr = ADDR_WIDTH'(HDR_TS_OFF);      hdr_data = ts_reg;         end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    busy       = 1'b0;
    case (state)
      ST_IDLE, ST_DONE: begin
        if (start) next_state = ST_INVALIDATE;
      end
      ST_INVALIDATE: begin
        mem_we     = 1'b1;
        mem_addr   = ADDR_WIDTH'(HDR_MAGIC_OFF);
        busy       = 1'b1;
        next_state = ST_ACCEPT;
      end
      ST_ACCEPT: begin
        if (transfer)    next_state = ST_WRITE_CONN;
        else if (commit) next_state = ST_WRITE_HDR;
      end
      ST_WRITE_CONN: begin
        mem_we    = 1'b1;
        mem_addr  = rec_addr;
        mem_wdata = DATA_WIDTH'(rec_words[word_idx]);
        busy      = 1'b1;
        if (last_word) next_state = (pend_commit || commit) ? ST_WRITE_HDR : ST_ACCEPT;
      end
      ST_WRITE_HDR: begin
        mem_we    = 1'b1;
        mem_addr  = hdr_addr;
        mem_wdata = DATA_WIDTH'(hdr_data);
        busy      = 1'b1;
        if (last_hdr) next_state = ST_DONE;
      end
      default: next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rec         <= '0;
      word_idx    <= '0;
      hdr_idx     <= '0;
      pend_commit <= 1'b0;
      ts_reg      <= '0;
      count       <= '0;
      ovf         <= 1'b0;
    end else begin
      if (start_ok) begin
        count       <= '0;
        ovf         <= 1'b0;
        pend_commit <= 1'b0;
      end
      if (transfer) begin
        rec      <= in_rec;
        word_idx <= '0;
      end
      if ((state == ST_ACCEPT) && conn_wr_valid && (count == MAX_CNT)) ovf <= 1'b1;
      // A commit that arrives with a record is deferred until that record is written
      if ((state == ST_ACCEPT) && commit) begin
        ts_reg      <= timestamp_in;
        hdr_idx     <= '0;
        pend_commit <= transfer;
      end
      if (state == ST_WRITE_CONN) begin
        word_idx <= last_word ? 4'd0 : word_idx + 4'd1;
        if (commit && !pend_commit) begin
          pend_commit <= 1'b1;
          ts_reg      <= timestamp_in;
        end
        if (last_word) begin
          count <= count + 7'd1;
          if (pend_commit || commit) begin
            pend_commit <= 1'b0;
            hdr_idx     <= '0;
          end
        end
      end
      if (state == ST_WRITE_HDR) hdr_idx <= hdr_idx + 2'd1;
    end
  end

endmodule

// File: tb/tb_fpga_config_writer.sv
// tb/tb_fpga_config_writer.sv - randomized self-checking bench with an in-bench image model
module tb_fpga_config_writer;

  localparam logic [31:0] MAGIC = 32'h41544746;

  typedef struct packed {
    logic [31:0] sw, host, lip, pip;
    logic [15:0] lport, pport, lqp, pqp;
    logic [47:0] lmac, pmac;
    logic        up;
  } rec_t;

  logic        clk = 1'b0, rst = 1'b1, start = 1'b0, commit = 1'b0;
  logic [31:0] timestamp_in = '0;
  logic        conn_wr_valid = 1'b0, conn_wr_ready;
  logic [31:0] conn_switch_id = '0, conn_host_id = '0, conn_local_ip = '0, conn_peer_ip = '0;
  logic [15:0] conn_local_port = '0, conn_peer_port = '0, conn_local_qp = '0, conn_peer_qp = '0;
  logic [47:0] conn_local_mac = '0, conn_peer_mac = '0;
  logic        conn_up = 1'b0;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_we, busy, done, overflow_error;
  logic [6:0]  conn_count;

  always #5 clk = ~clk;

  fpga_config_writer dut (
    .clk(clk), .rst(rst), .start(start), .commit(commit), .timestamp_in(timestamp_in),
    .conn_wr_valid(conn_wr_valid), .conn_wr_ready(conn_wr_ready),
    .conn_switch_id(conn_switch_id), .conn_host_id(conn_host_id),
    .conn_local_ip(conn_local_ip), .conn_peer_ip(conn_peer_ip),
    .conn_local_port(conn_local_port), .conn_peer_port(conn_peer_port),
    .conn_local_qp(conn_local_qp), .conn_peer_qp(conn_peer_qp),
    .conn_local_mac(conn_local_mac), .conn_peer_mac(conn_peer_mac), .conn_up(conn_up),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
    .busy(busy), .done(done), .overflow_error(overflow_error), .conn_count(conn_count)
  );

  int          checks = 0, errors = 0;
  logic [31:0] exp_addr[$], exp_data[$];
  logic [31:0] mem_model [0:1023];
  logic [31:0] last_addr = 32'hFFFF_FFFF;
  rec_t        recs [0:63];
  int          model_count = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic void push_w(input int a, input logic [31:0] d);
    exp_addr.push_back(32'(a));
    exp_data.push_back(d);
  endfunction

  // Record image: plain fields, then the 12 MAC octets as a little-endian byte stream
  function automatic void push_record(input rec_t r, input int idx);
    logic [7:0]  mb [12];
    logic [31:0] w  [11];
    for (int j = 0; j < 6; j++) begin
      mb[j]     = r.lmac[8*(5-j) +: 8];
      mb[6 + j] = r.pmac[8*(5-j) +: 8];
    end
    w[0] = r.sw; w[1] = r.host; w[2] = r.lip; w[3] = r.pip;
    w[4] = (32'(r.pport) << 16) | 32'(r.lport);
    w[5] = (32'(r.pqp) << 16) | 32'(r.lqp);
    for (int j = 0; j < 3; j++)
      w[6 + j] = 32'(mb[4*j]) | (32'(mb[4*j+1]) << 8) | (32'(mb[4*j+2]) << 16) | (32'(mb[4*j+3]) << 24);
    w[9] = 32'(r.up);
    w[10] = 32'h0;
    for (int k = 0; k < 11; k++) push_w(16 + 44 * idx + 4 * k, w[k]);
  endfunction

  function automatic void push_header(input int n, input logic [31:0] ts);
    push_w(4, 32'h1);
    push_w(8, 32'(n));
    push_w(12, ts);
    push_w(0, MAGIC);
  endfunction

  function automatic rec_t rand_rec();
    rec_t r;
    r.sw = $urandom; r.host = $urandom; r.lip = $urandom; r.pip = $urandom;
    r.lport = 16'($urandom); r.pport = 16'($urandom);
    r.lqp = 16'($urandom); r.pqp = 16'($urandom);
    r.lmac = {16'($urandom), $urandom}; r.pmac = {16'($urandom), $urandom};
    r.up = 1'($urandom);
    return r;
  endfunction

  always @(negedge clk) begin
    if (!rst && mem_we) begin
      checks++;
      if (exp_addr.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write: addr=%0h data=%0h", mem_addr, mem_wdata);
      end else begin
        logic [31:0] ea, ed;
        ea = exp_addr.pop_front();
        ed = exp_data.pop_front();
        if (mem_addr !== ea || mem_wdata !== ed) begin
          errors++;
          $display("FAIL write: got addr=%0h data=%0h expected addr=%0h data=%0h", mem_addr, mem_wdata, ea, ed);
        end
      end
      if (!busy) begin
        errors++;
        $display("FAIL busy_during_write: got 0 expected 1");
      end
      mem_model[mem_addr[11:2]] = mem_wdata;
      last_addr = mem_addr;
    end
  end

  task automatic drive(input rec_t r);
    conn_switch_id = r.sw; conn_host_id = r.host; conn_local_ip = r.lip; conn_peer_ip = r.pip;
    conn_local_port = r.lport; conn_peer_port = r.pport;
    conn_local_qp = r.lqp; conn_peer_qp = r.pqp;
    conn_local_mac = r.lmac; conn_peer_mac = r.pmac; conn_up = r.up;
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_we"}, mem_we, 0);
    chk({tag, "_addr"}, mem_addr, 0);
    chk({tag, "_wdata"}, mem_wdata, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_ovf"}, overflow_error, 0);
    chk({tag, "_ready"}, conn_wr_ready, 0);
    chk({tag, "_count"}, conn_count, 0);
  endtask

  task automatic do_start();
    @(negedge clk);
    start = 1'b1;
    for (int i = 0; i < 1024; i++) mem_model[i] = 32'hDEAD_BEEF;
    push_w(0, 32'h0);
    model_count = 0;
    @(posedge clk); #1;
    start = 1'b0;
    chk("start_busy", busy, 1);
    chk("start_done_clr", done, 0);
    chk("start_ovf_clr", overflow_error, 0);
    chk("start_count_clr", conn_count, 0);
  endtask

  task automatic do_record(input rec_t r, input bit with_commit, input logic [31:0] ts, input int gap);
    int guard;
    repeat (gap) @(negedge clk);
    @(negedge clk);
    drive(r);
    conn_wr_valid = 1'b1;
    guard = 0;
    while (!conn_wr_ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (!conn_wr_ready) begin
      chk("ready_timeout", 0, 1);
      conn_wr_valid = 1'b0;
      return;
    end
    commit = with_commit;
    timestamp_in = ts;
    recs[model_count] = r;
    push_record(r, model_count);
    model_count++;
    if (with_commit) push_header(model_count, ts);
    @(posedge clk); #1;
    conn_wr_valid = 1'b0;
    commit = 1'b0;
  endtask

  task automatic wait_not_busy();
    int guard = 0;
    @(negedge clk);
    while (busy && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (busy) chk("not_busy_timeout", busy, 0);
  endtask

  task automatic commit_idle(input logic [31:0] ts);
    wait_not_busy();
    @(negedge clk);
    commit = 1'b1;
    timestamp_in = ts;
    push_header(model_count, ts);
    @(posedge clk); #1;
    commit = 1'b0;
  endtask

  task automatic commit_mid(input logic [31:0] ts);
    int d = $urandom_range(0, 10);
    push_header(model_count, ts);
    repeat (d) @(posedge clk);
    #1;
    commit = 1'b1;
    timestamp_in = ts;
    @(posedge clk); #1;
    commit = 1'b0;
  endtask

  task automatic wait_done(input int n);
    int guard = 0;
    while (!done && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    @(negedge clk);
    chk("done_seen", done, 1);
    chk("queue_drained", exp_addr.size(), 0);
    chk("count_out", conn_count, 64'(n));
    chk("magic_written_last", last_addr, 0);
    chk("busy_after_done", busy, 0);
  endtask

  task automatic verify_image(input int n, input logic [31:0] ts);
    chk("rt_magic", mem_model[0], MAGIC);
    chk("rt_version", mem_model[1], 32'h1);
    chk("rt_count", mem_model[2], 64'(n));
    chk("rt_ts", mem_model[3], ts);
    for (int i = 0; i < n; i++) begin
      rec_t        d;
      logic [7:0]  mb [12];
      logic [31:0] wd;
      int          base = 4 + 11 * i;
      d.sw = mem_model[base]; d.host = mem_model[base+1];
      d.lip = mem_model[base+2]; d.pip = mem_model[base+3];
      wd = mem_model[base+4]; d.lport = wd[15:0]; d.pport = wd[31:16];
      wd = mem_model[base+5]; d.lqp = wd[15:0]; d.pqp = wd[31:16];
      for (int j = 0; j < 3; j++) begin
        wd = mem_model[base+6+j];
        for (int b = 0; b < 4; b++) mb[4*j+b] = wd[8*b +: 8];
      end
      d.lmac = {mb[0], mb[1], mb[2], mb[3], mb[4], mb[5]};
      d.pmac = {mb[6], mb[7], mb[8], mb[9], mb[10], mb[11]};
      wd = mem_model[base+9];
      d.up = wd[0];
      checks++;
      if (d !== recs[i] || wd[31:1] !== 31'h0 || mem_model[base+10] !== 32'h0) begin
        errors++;
        $display("FAIL rt_record %0d: got sw=%0h lmac=%0h pmac=%0h expected sw=%0h lmac=%0h pmac=%0h",
                 i, d.sw, d.lmac, d.pmac, recs[i].sw, recs[i].lmac, recs[i].pmac);
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rec_t r;
    logic [31:0] ts;

    repeat (3) @(posedge clk);
    #2;
    check_reset_vals("reset");
    @(negedge clk);
    rst = 1'b0;

    // Single known record, header pinned by hand-computed literals
    do_start();
    r = '0;
    r.sw = 32'd5; r.lmac = 48'h001122334455; r.pmac = 48'hAABBCCDDEEFF; r.up = 1'b1;
    do_record(r, 1'b0, 32'h0, 0);
    commit_idle(32'h12345678);
    wait_done(1);
    verify_image(1, 32'h12345678);
    chk("lit_w0", mem_model[4], 32'd5);
    chk("lit_w6", mem_model[10], 32'h33221100);
    chk("lit_w7", mem_model[11], 32'hBBAA5544);
    chk("lit_w8", mem_model[12], 32'hFFEEDDCC);
    chk("lit_w9", mem_model[13], 32'h1);
    chk("lit_count", mem_model[2], 32'h1);
    chk("lit_ts", mem_model[3], 32'h12345678);
    chk("lit_magic", mem_model[0], 32'h41544746);

    // Commit together with the third transfer
    do_start();
    ts = $urandom;
    for (int i = 0; i < 3; i++) do_record(rand_rec(), i == 2, ts, 0);
    wait_done(3);
    verify_image(3, ts);
    chk("third_rec_at_104", mem_model[104/4], recs[2].sw);

    // Zero-record image, with a start pulse while busy writing the header
    do_start();
    wait_not_busy();
    @(negedge clk);
    ts = $urandom;
    commit = 1'b1;
    timestamp_in = ts;
    push_header(0, ts);
    @(posedge clk); #1;
    commit = 1'b0;
    @(negedge clk);
    chk("hdr_busy", busy, 1);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(0);
    verify_image(0, ts);

    // Fill to capacity, then overflow
    do_start();
    for (int i = 0; i < 64; i++) do_record(rand_rec(), 1'b0, 32'h0, 0);
    wait_not_busy();
    chk("full_ready_low", conn_wr_ready, 0);
    chk("full_count", conn_count, 64);
    @(negedge clk);
    drive(rand_rec());
    conn_wr_valid = 1'b1;
    @(posedge clk); #1;
    conn_wr_valid = 1'b0;
    chk("overflow_set", overflow_error, 1);
    ts = $urandom;
    commit_idle(ts);
    wait_done(64);
    verify_image(64, ts);
    chk("last_rec_at_2788", mem_model[2788/4], recs[63].sw);
    chk("overflow_sticky", overflow_error, 1);

    // Reset on the fifth word of a record
    do_start();
    do_record(rand_rec(), 1'b0, 32'h0, 0);
    repeat (4) @(posedge clk);
    #2;
    chk("word5_we", mem_we, 1);
    chk("word5_addr", mem_addr, 32);
    rst = 1'b1;
    #1;
    check_reset_vals("midreset");
    exp_addr.delete();
    exp_data.delete();
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    chk("magic_stays_zero", mem_model[0], 0);
    chk("idle_after_reset_busy", busy, 0);

    // Randomized images with varied commit placement and record gaps
    for (int it = 0; it < 8; it++) begin
      int n, mode;
      do_start();
      n = $urandom_range(0, 6);
      mode = $urandom_range(0, 2);
      ts = $urandom;
      for (int i = 0; i < n; i++)
        do_record(rand_rec(), (i == n - 1) && (mode == 0), ts, $urandom_range(0, 3));
      if (mode == 1 && n > 0) commit_mid(ts);
      else if (!(mode == 0 && n > 0)) commit_idle(ts);
      wait_done(n);
      verify_image(n, ts);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
